// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared receiver state, parity-mode types, error-tag indices and parity helper
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    EVEN = 2'b01,
    ODD  = 2'b10
  } parity_mode_t;

  localparam int ERR_BREAK  = 0;
  localparam int ERR_PARITY = 1;
  localparam int ERR_FRAME  = 2;

  // Expected parity bit; callers zero-extend narrower words so the upper bits do not contribute.
  function automatic logic calc_parity(input logic [8:0] data, input parity_mode_t mode);
    return (^data) ^ (mode == ODD);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through queue with wrap-bit pointers and sticky overflow
module uart_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_tdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_tdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic                   overflow_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             overflow_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o      = (wr_ptr_q == rd_ptr_q);
  assign full_o       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o      = wr_ptr_q - rd_ptr_q;
  assign do_pop       = pop_i && !empty_o;
  // A pop in the same cycle frees the head slot, so a push into a full queue still lands.
  assign do_push      = push_i && (!full_o || do_pop);
  assign head_tdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign overflow_o   = overflow_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_tdata_i;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_i && !do_push) begin
        overflow_q <= 1'b1;
      end else if (do_pop) begin
        overflow_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - oversampled MSB-first UART receiver feeding a tagged FWFT queue
// Define UART_RX_MAJORITY_VOTE_EN to resolve each bit by 2-of-3 vote around mid-bit.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int SYSCLK_RATE = 100000000,
  parameter int BAUD_RATE   = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                 SysClk,
  input  logic                 Rst,
  input  logic                 Rx,
  input  logic [1:0]           Parity_Mode,
  input  logic                 Read_Done,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic [2:0]           Rx_Error,
  output logic                 Data_Rdy,
  output logic                 FIFO_Empty,
  output logic                 FIFO_Full,
  output logic                 FIFO_Overflow,
  output logic                 RTS,
  output logic                 Rx_Busy
);
  localparam int DIV_RAW = SYSCLK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = $clog2(DIV) + 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int HALF    = OVERSAMPLE / 2;
  localparam int WW      = DATA_BITS + 3;
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;

  rx_state_t             state_q, state_d;
  parity_mode_t          mode_q;
  logic                  rx_meta_q, rx_sync_q, rx_prev_q;
  logic [DW-1:0]         div_cnt_q;
  logic [SW-1:0]         smp_cnt_q;
  logic [3:0]            bit_cnt_q;
  logic [DATA_BITS-1:0]  data_q;
  logic                  par_err_q, frm_err_q, all_zero_q;
  logic                  samp_b_q;
  logic                  push_q, push_d;
  logic [WW-1:0]         push_data_q, push_word;
  logic                  rts_q;
  logic [CW-1:0]         fifo_count;
  logic [WW-1:0]         head;
  logic [2:0]            tag;
  logic                  fall, tick, decide, bit_val, is_break, last_data, last_stop;

  assign fall      = rx_prev_q & ~rx_sync_q;
  assign tick      = (div_cnt_q == DW'(DIV - 1));
  // Bits are resolved one tick after mid-bit so both sampling builds share identical timing.
  assign decide    = tick && (smp_cnt_q == SW'(HALF));
  assign last_data = (bit_cnt_q == 4'(DATA_BITS - 1));
  assign last_stop = (bit_cnt_q == 4'(STOP_BITS - 1));

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic samp_a_q;
  assign bit_val = (samp_a_q & samp_b_q) | (samp_a_q & rx_sync_q) | (samp_b_q & rx_sync_q);
`else
  assign bit_val = samp_b_q;
`endif

  always_comb begin
    state_d  = state_q;
    push_d   = 1'b0;
    is_break = all_zero_q & ~bit_val;
    tag      = '0;
    tag[ERR_BREAK]  = is_break;
    tag[ERR_PARITY] = par_err_q & ~is_break;
    tag[ERR_FRAME]  = (frm_err_q | ~bit_val) & ~is_break;
    push_word = {tag, data_q & {DATA_BITS{~is_break}}};
    unique case (state_q)
      IDLE:       if (fall) state_d = START;
      START:      if (decide) state_d = bit_val ? IDLE : DATA;
      DATA:       if (decide && last_data) state_d = (mode_q == NONE) ? STOP : PARITY;
      PARITY:     if (decide) state_d = STOP;
      STOP: begin
        if (decide && last_stop) begin
          push_d  = 1'b1;
          state_d = is_break ? BREAK_WAIT : IDLE;
        end
      end
      BREAK_WAIT: if (rx_sync_q) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge SysClk) begin
    if (!Rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      mode_q      <= NONE;
      div_cnt_q   <= '0;
      smp_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      data_q      <= '0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      all_zero_q  <= 1'b0;
      samp_b_q    <= 1'b1;
      push_q      <= 1'b0;
      push_data_q <= '0;
      rts_q       <= 1'b1;
`ifdef UART_RX_MAJORITY_VOTE_EN
      samp_a_q    <= 1'b1;
`endif
    end else begin
      rx_meta_q <= Rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      push_q    <= push_d;
      rts_q     <= (fifo_count < CW'(FIFO_DEPTH - 1));
      if (push_d) push_data_q <= push_word;

      if (state_q == IDLE) begin
        div_cnt_q <= '0;
        smp_cnt_q <= '0;
      end else if (tick) begin
        div_cnt_q <= '0;
        smp_cnt_q <= (smp_cnt_q == SW'(OVERSAMPLE - 1)) ? '0 : smp_cnt_q + 1'b1;
      end else begin
        div_cnt_q <= div_cnt_q + 1'b1;
      end

      if (tick && smp_cnt_q == SW'(HALF - 1)) samp_b_q <= rx_sync_q;
`ifdef UART_RX_MAJORITY_VOTE_EN
      if (tick && smp_cnt_q == SW'(HALF - 2)) samp_a_q <= rx_sync_q;
`endif

      if (state_q == IDLE && fall) begin
        mode_q     <= (Parity_Mode == 2'b11) ? NONE : parity_mode_t'(Parity_Mode);
        par_err_q  <= 1'b0;
        frm_err_q  <= 1'b0;
        all_zero_q <= 1'b1;
        bit_cnt_q  <= '0;
      end

      if (decide) begin
        unique case (state_q)
          DATA: begin
            data_q     <= {data_q[DATA_BITS-2:0], bit_val};
            all_zero_q <= all_zero_q & ~bit_val;
            bit_cnt_q  <= last_data ? 4'd0 : bit_cnt_q + 4'd1;
          end
          PARITY: begin
            par_err_q  <= (bit_val != calc_parity(9'(data_q), mode_q));
            all_zero_q <= all_zero_q & ~bit_val;
          end
          STOP: begin
            frm_err_q  <= frm_err_q | ~bit_val;
            all_zero_q <= all_zero_q & ~bit_val;
            bit_cnt_q  <= last_stop ? 4'd0 : bit_cnt_q + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  uart_rx_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (SysClk),
    .rstn_i       (Rst),
    .push_i       (push_q),
    .push_tdata_i (push_data_q),
    .pop_i        (Read_Done),
    .head_tdata_o (head),
    .count_o      (fifo_count),
    .empty_o      (FIFO_Empty),
    .full_o       (FIFO_Full),
    .overflow_o   (FIFO_Overflow)
  );

  assign Data_Out = head[DATA_BITS-1:0];
  assign Rx_Error = head[WW-1:DATA_BITS];
  assign Data_Rdy = ~FIFO_Empty;
  assign RTS      = rts_q;
  assign Rx_Busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb/tb_uart_rx_oversample.sv - randomized scoreboard bench for uart_rx_oversample
module tb_uart_rx_oversample;
  localparam int DB       = 8;
  localparam int DEPTH    = 8;
  localparam int BIT_CLKS = 16;

  logic          SysClk = 1'b0;
  logic          Rst, Rx, Read_Done;
  logic [1:0]    Parity_Mode;
  logic [DB-1:0] Data_Out;
  logic [2:0]    Rx_Error;
  logic          Data_Rdy, FIFO_Empty, FIFO_Full, FIFO_Overflow, RTS, Rx_Busy;

  int            checks = 0;
  int            failures = 0;
  logic [DB+2:0] exp_q [$];
  bit            reader_en = 1'b0;
  bit            exp_ovf = 1'b0;

  always #5 SysClk = ~SysClk;

  uart_rx_oversample #(
    .SYSCLK_RATE (1600000),
    .BAUD_RATE   (100000),
    .OVERSAMPLE  (16),
    .DATA_BITS   (DB),
    .STOP_BITS   (2),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .SysClk        (SysClk),
    .Rst           (Rst),
    .Rx            (Rx),
    .Parity_Mode   (Parity_Mode),
    .Read_Done     (Read_Done),
    .Data_Out      (Data_Out),
    .Rx_Error      (Rx_Error),
    .Data_Rdy      (Data_Rdy),
    .FIFO_Empty    (FIFO_Empty),
    .FIFO_Full     (FIFO_Full),
    .FIFO_Overflow (FIFO_Overflow),
    .RTS           (RTS),
    .Rx_Busy       (Rx_Busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: tag derived from the frame content alone.
  function automatic logic [DB+2:0] model_word(input logic [DB-1:0] d, input logic [1:0] pm,
                                               input logic p, input logic [1:0] stops);
    bit has_par;
    has_par = (pm == 2'd1) || (pm == 2'd2);
    if (d == '0 && (!has_par || !p) && stops == 2'b00) return {3'b001, {DB{1'b0}}};
    return {stops != 2'b11, has_par && (p != ((^d) ^ (pm == 2'd2))), 1'b0, d};
  endfunction

  task automatic expect_word(input logic [DB+2:0] w);
    if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
    else exp_q.push_back(w);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic [1:0] pm, input logic p,
                            input logic [1:0] stops, input int flip);
    logic bits [$];
    bits.push_back(1'b0);
    for (int i = DB - 1; i >= 0; i--) bits.push_back(d[i]);
    if (pm == 2'd1 || pm == 2'd2) bits.push_back(p);
    bits.push_back(stops[1]);
    bits.push_back(stops[0]);
    Parity_Mode = pm;
    for (int c = 0; c < bits.size() * BIT_CLKS; c++) begin
      @(negedge SysClk);
      Rx = bits[c / BIT_CLKS] ^ (c == flip);
    end
    @(negedge SysClk);
    Rx = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge SysClk);
  endtask

  // Monitor: pops and compares whenever the DUT presents a word.
  initial begin
    Read_Done = 1'b0;
    forever begin
      @(negedge SysClk);
      Read_Done = 1'b0;
      if (reader_en && Rst && Data_Rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got %0h expected no entry", {Rx_Error, Data_Out});
        end else begin
          check("word", {Rx_Error, Data_Out}, exp_q.pop_front());
          exp_ovf = 1'b0;
        end
        Read_Done = 1'b1;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [DB-1:0] d;
    logic [1:0]    pm, st;
    logic          p;
    int            err;

    Rst = 1'b0;
    Rx = 1'b1;
    Parity_Mode = 2'd0;
    repeat (4) @(negedge SysClk);
    check("rst_data_out", Data_Out, 0);
    check("rst_rx_error", Rx_Error, 0);
    check("rst_data_rdy", Data_Rdy, 0);
    check("rst_fifo_empty", FIFO_Empty, 1);
    check("rst_fifo_full", FIFO_Full, 0);
    check("rst_overflow", FIFO_Overflow, 0);
    check("rst_rts", RTS, 1);
    check("rst_busy", Rx_Busy, 0);
    Rst = 1'b1;
    reader_en = 1'b1;
    repeat (4) @(negedge SysClk);

    expect_word(model_word(8'hA5, 2'd1, 1'b0, 2'b11));
    send_frame(8'hA5, 2'd1, 1'b0, 2'b11, -1);
    check("good_read_empty", FIFO_Empty, 1);
    expect_word(model_word(8'hAA, 2'd2, 1'b0, 2'b11));
    send_frame(8'hAA, 2'd2, 1'b0, 2'b11, -1);
    expect_word(model_word(8'h3C, 2'd1, 1'b0, 2'b00));
    send_frame(8'h3C, 2'd1, 1'b0, 2'b00, -1);

    expect_word({3'b001, {DB{1'b0}}});
    Parity_Mode = 2'd1;
    for (int c = 0; c < 20 * BIT_CLKS; c++) begin
      @(negedge SysClk);
      Rx = 1'b0;
    end
    check("break_wait_busy", Rx_Busy, 1);
    @(negedge SysClk);
    Rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge SysClk);
    check("break_exit_busy", Rx_Busy, 0);
    check("break_single_entry", exp_q.size(), 0);

    repeat (4) begin
      @(negedge SysClk);
      Rx = 1'b0;
    end
    @(negedge SysClk);
    Rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge SysClk);
    check("glitch_empty", FIFO_Empty, 1);
    check("glitch_busy", Rx_Busy, 0);

    for (int c = 0; c < 4 * BIT_CLKS; c++) begin
      @(negedge SysClk);
      Rx = (c >= BIT_CLKS);
    end
    check("midframe_busy", Rx_Busy, 1);
    Rst = 1'b0;
    Rx = 1'b1;
    repeat (4) @(negedge SysClk);
    Rst = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge SysClk);
    check("midframe_reset_busy", Rx_Busy, 0);
    check("midframe_reset_empty", FIFO_Empty, 1);

`ifdef UART_RX_MAJORITY_VOTE_EN
    expect_word({3'b000, 8'h0F});
`else
    expect_word({3'b000, 8'h8F});
`endif
    send_frame(8'h0F, 2'd0, 1'b0, 2'b11, BIT_CLKS + BIT_CLKS / 2);

    reader_en = 1'b0;
    for (int w = 0; w < 9; w++) begin
      d = DB'(w);
      expect_word(model_word(d, 2'd1, ^d, 2'b11));
      send_frame(d, 2'd1, ^d, 2'b11, -1);
      check("fill_full", FIFO_Full, exp_q.size() == DEPTH);
      check("fill_rts", RTS, exp_q.size() < DEPTH - 1);
      check("fill_overflow", FIFO_Overflow, exp_ovf);
    end
    @(posedge SysClk);
    reader_en = 1'b1;
    @(negedge SysClk);
    check("overflow_before_read", FIFO_Overflow, 1);
    @(negedge SysClk);
    check("overflow_after_read", FIFO_Overflow, 0);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge SysClk);
    check("fill_drained", exp_q.size(), 0);
    repeat (4) @(negedge SysClk);
    check("fill_rts_restored", RTS, 1);

    repeat (25) begin
      d   = DB'($urandom);
      pm  = 2'($urandom_range(0, 3));
      err = int'($urandom_range(0, 3));
      p   = (^d) ^ (pm == 2'd2) ^ (err == 1);
      st  = (err == 2) ? 2'($urandom_range(0, 2)) : 2'b11;
      if (err == 3) begin
        d  = '0;
        p  = 1'b0;
        st = 2'b00;
      end
      expect_word(model_word(d, pm, p, st));
      send_frame(d, pm, p, st, -1);
    end
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge SysClk);
    check("final_drained", exp_q.size(), 0);
    check("final_empty", FIFO_Empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
